// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : RAW hazard detector for the ID stage. Counts in-flight register
//            writes in EX..MEM and stalls ID/IF while a source is pending.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_COUNT  = 16,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [3:0]           id_src1,
    input  logic [3:0]           id_src2,
    input  logic                 id_use_src2,
    input  logic                 id_wb_en,
    input  logic [3:0]           id_dest,
    input  logic                 flush,
    output logic                 hazard_stall,
    output logic [REG_COUNT-1:0] pend_mask,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int              CW        = $clog2(PIPE_DEPTH + 1);
    localparam int              LAST      = PIPE_DEPTH - 1;
    localparam logic [CW-1:0]   C_CNT_MAX = CW'(PIPE_DEPTH);

    logic                 r_st_v    [PIPE_DEPTH];
    logic                 r_st_wb   [PIPE_DEPTH];
    logic [3:0]           r_st_dest [PIPE_DEPTH];
    logic [CW-1:0]        r_pend_cnt [REG_COUNT];
    logic [CW-1:0]        w_cnt_nxt  [REG_COUNT];
    logic [CNT_W-1:0]     r_stall_count;

    logic                 w_issue;
    logic                 w_inc;
    logic                 w_dec;
    logic [REG_COUNT-1:0] w_inc_vec;
    logic [REG_COUNT-1:0] w_dec_vec;

    generate
        for (genvar r = 0; r < REG_COUNT; r++) begin : g_mask
            assign pend_mask[r] = (r_pend_cnt[r] != '0);
        end
    endgenerate

    // The ID instruction's own destination is not tracked yet, so a
    // self-dependency can never raise a stall here.
    assign hazard_stall = id_valid & ~flush &
                          (pend_mask[id_src1] | (id_use_src2 & pend_mask[id_src2]));

    assign w_issue   = id_valid & ~flush & ~hazard_stall;
    assign w_inc     = w_issue & id_wb_en;
    assign w_dec     = r_st_v[LAST] & r_st_wb[LAST];
    assign w_inc_vec = w_inc ? (REG_COUNT'(1) << id_dest) : '0;
    assign w_dec_vec = w_dec ? (REG_COUNT'(1) << r_st_dest[LAST]) : '0;

    // EX/MEM never stall: the shift register advances every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_st_v[k]    <= 1'b0;
                r_st_wb[k]   <= 1'b0;
                r_st_dest[k] <= '0;
            end
        end else begin
            r_st_v[0]    <= w_issue;
            r_st_wb[0]   <= w_issue & id_wb_en;
            r_st_dest[0] <= w_issue ? id_dest : 4'd0;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_st_v[k]    <= r_st_v[k-1];
                r_st_wb[k]   <= r_st_wb[k-1];
                r_st_dest[k] <= r_st_dest[k-1];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            w_cnt_nxt[r] = r_pend_cnt[r];
            if (w_inc_vec[r] && !w_dec_vec[r]) begin
                w_cnt_nxt[r] = r_pend_cnt[r] + CW'(1);
            end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
                w_cnt_nxt[r] = r_pend_cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_pend_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                r_pend_cnt[r] <= w_cnt_nxt[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (hazard_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

`ifndef SYNTHESIS
    // A counter leaving 0..PIPE_DEPTH means the tracking itself is broken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (w_inc_vec[r] && !w_dec_vec[r]) begin
                    assert (r_pend_cnt[r] != C_CNT_MAX);
                end
                if (w_dec_vec[r] && !w_inc_vec[r]) begin
                    assert (r_pend_cnt[r] != '0);
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed self-checking bench for hazard_scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use_src2;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        flush;
    logic        hazard_stall;
    logic [15:0] pend_mask;
    logic [15:0] stall_count;
    logic        hazard_stall_s;
    logic [15:0] pend_mask_s;
    logic [3:0]  stall_count_s;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(.REG_COUNT(16), .PIPE_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .flush(flush), .hazard_stall(hazard_stall),
        .pend_mask(pend_mask), .stall_count(stall_count)
    );

    hazard_scoreboard #(.REG_COUNT(16), .PIPE_DEPTH(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .flush(flush), .hazard_stall(hazard_stall_s),
        .pend_mask(pend_mask_s), .stall_count(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic u2, input logic wb, input logic [3:0] d,
                          input logic fl);
        id_valid    = v;
        id_src1     = s1;
        id_src2     = s2;
        id_use_src2 = u2;
        id_wb_en    = wb;
        id_dest     = d;
        flush       = fl;
    endtask

    initial begin
        rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", 32'(hazard_stall), 0);
        chk("reset_mask", 32'(pend_mask), 0);
        chk("reset_count", 32'(stall_count), 0);
        #2 rst = 1'b1;
        tick();

        // RAW distance 1: ADD R3 then SUB reading R3
        set_id(1, 0, 0, 0, 1, 3, 0); #1;
        chk("raw_first_nostall", 32'(hazard_stall), 0);
        tick();
        set_id(1, 3, 0, 0, 1, 4, 0); #1;
        chk("raw_stall_c1", 32'(hazard_stall), 1);
        chk("raw_mask_r3", 32'(pend_mask), 32'h0008);
        tick();
        chk("raw_stall_c2", 32'(hazard_stall), 1);
        chk("raw_ex_bubble", 32'(dut.r_st_v[0]), 0);
        tick();
        chk("raw_release", 32'(hazard_stall), 0);
        chk("raw_count", 32'(stall_count), 2);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0); #1;
        chk("raw_sub_issued", 32'(pend_mask), 32'h0010);
        tick(); tick();
        chk("raw_drained", 32'(pend_mask), 0);

        // src2 only matters when it is actually read
        set_id(1, 0, 0, 0, 1, 3, 0); tick();
        set_id(1, 0, 3, 0, 0, 0, 0); #1;
        chk("src2_gated", 32'(hazard_stall), 0);
        tick();
        set_id(1, 0, 3, 1, 0, 0, 0); #1;
        chk("src2_used", 32'(hazard_stall), 1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("src2_count", 32'(stall_count), 3);

        // Two back-to-back writers of R5
        set_id(1, 0, 0, 0, 1, 5, 0); #1;
        chk("dbl_first_nostall", 32'(hazard_stall), 0);
        tick();
        chk("dbl_mask_p1", 32'(pend_mask), 32'h0020);
        tick();
        chk("dbl_cnt2", 32'(dut.r_pend_cnt[5]), 2);
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("dbl_mask_p3", 32'(pend_mask), 32'h0020);
        chk("dbl_cnt1", 32'(dut.r_pend_cnt[5]), 1);
        tick();
        chk("dbl_mask_p4", 32'(pend_mask), 0);

        // Issue and retire on the same register in one cycle
        set_id(1, 0, 0, 0, 1, 6, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 1, 6, 0); tick();
        chk("incdec_cnt", 32'(dut.r_pend_cnt[6]), 1);
        chk("incdec_mask", 32'(pend_mask), 32'h0040);
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("incdec_drained", 32'(pend_mask), 0);

        // Flush beats a hazard and squashes the write
        set_id(1, 0, 0, 0, 1, 8, 0); tick();
        set_id(1, 8, 0, 0, 1, 9, 1); #1;
        chk("flush_nostall", 32'(hazard_stall), 0);
        tick();
        chk("flush_mask", 32'(pend_mask), 32'h0100);
        chk("flush_bubble", 32'(dut.r_st_v[0]), 0);
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("flush_drained", 32'(pend_mask), 0);
        chk("flush_count", 32'(stall_count), 3);
        chk("sat_early", 32'(stall_count_s), 3);

        // Self-dependency is not a hazard
        set_id(1, 2, 2, 1, 1, 2, 0); #1;
        chk("self_dep", 32'(hazard_stall), 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Ten RAW pairs: 20 more stall cycles, 4-bit counter pins at 15
        for (int i = 0; i < 10; i++) begin
            set_id(1, 0, 0, 0, 1, 3, 0); tick();
            set_id(1, 3, 0, 0, 0, 0, 0); tick(); tick(); tick();
        end
        set_id(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("sat_wide_count", 32'(stall_count), 23);
        chk("sat_narrow_count", 32'(stall_count_s), 15);

        // Asynchronous reset mid-operation
        set_id(1, 0, 0, 0, 1, 10, 0); tick();
        set_id(1, 10, 0, 0, 0, 0, 0); #1;
        chk("midrst_pre_stall", 32'(hazard_stall), 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_mask", 32'(pend_mask), 0);
        chk("midrst_stall", 32'(hazard_stall), 0);
        chk("midrst_count", 32'(stall_count), 0);
        chk("midrst_sat_count", 32'(stall_count_s), 0);
        #2 rst = 1'b1;
        tick();
        chk("postrst_stall", 32'(hazard_stall), 0);
        chk("postrst_mask", 32'(pend_mask), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
